// File: rtl/interrupt_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_sequencer
// Description : Sits between the memory data bus and the control FSM opcode
//               input. It tracks reset, NMI and IRQ requests. At each
//               instruction boundary it substitutes BRK_OPCODE for the
//               fetched opcode when an interrupt is taken. It also supplies
//               the vector address, the B-flag value and the stack-write
//               suppress to the datapath for the BRK microcode.
//               Optional macro INT_SYNC_EN adds SYNC_STAGES-deep
//               synchronizers on nmi_b/irq_b.
// Revision    : 1.0 - initial release
// ============================================================================
module interrupt_sequencer #(
    parameter logic [7:0] BRK_OPCODE  = 8'h00,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        ph1,
    input  logic        reset,
    input  logic [7:0]  data_in,
    input  logic        last_cycle,
    input  logic        p_i,
    input  logic        nmi_b,
    input  logic        irq_b,
    input  logic        vec_ack,
    output logic [7:0]  opcode_out,
    output logic [15:0] vector_addr,
    output logic        b_flag,
    output logic        wr_suppress,
    output logic        int_active
);

    localparam logic [1:0] c_ST_RST_PEND = 2'd0;
    localparam logic [1:0] c_ST_IDLE     = 2'd1;
    localparam logic [1:0] c_ST_INJECT   = 2'd2;
    localparam logic [1:0] c_ST_SERVICE  = 2'd3;

    localparam logic [1:0] c_SRC_RST = 2'd0;
    localparam logic [1:0] c_SRC_NMI = 2'd1;
    localparam logic [1:0] c_SRC_IRQ = 2'd2;
    localparam logic [1:0] c_SRC_BRK = 2'd3;

    // A zero-depth synchronizer would leave the chain without a tap
    if (SYNC_STAGES < 1) begin : g_bad_sync_stages
        $error("SYNC_STAGES must be at least 1");
    end

    logic [1:0] r_state;
    logic [1:0] r_src;
    logic       r_nmi_pend;
    logic       r_nmi_prev;
    logic       r_first_cycle;
    logic       r_b_flag;
    logic       r_wr_suppress;
    logic       w_nmi_s;
    logic       w_irq_s;
    logic       w_irq_lvl;
    logic       w_nmi_fall;
    logic       w_nmi_clear;

`ifdef INT_SYNC_EN
    logic [SYNC_STAGES-1:0] r_nmi_sync;
    logic [SYNC_STAGES-1:0] r_irq_sync;

    // Request synchronizers; idle level is high so reset loads ones
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            r_nmi_sync <= '1;
            r_irq_sync <= '1;
        end else begin
            r_nmi_sync[0] <= nmi_b;
            r_irq_sync[0] <= irq_b;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_nmi_sync[i] <= r_nmi_sync[i-1];
                r_irq_sync[i] <= r_irq_sync[i-1];
            end
        end
    end

    assign w_nmi_s = r_nmi_sync[SYNC_STAGES-1];
    assign w_irq_s = r_irq_sync[SYNC_STAGES-1];
`else
    assign w_nmi_s = nmi_b;
    assign w_irq_s = irq_b;
`endif

    assign w_irq_lvl   = ~w_irq_s;
    assign w_nmi_fall  = r_nmi_prev & ~w_nmi_s;
    assign w_nmi_clear = (r_state == c_ST_SERVICE) && vec_ack && (r_src == c_SRC_NMI);

    // NMI edge detector; a new edge wins over the acknowledge clear
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            r_nmi_prev <= 1'b1;
            r_nmi_pend <= 1'b0;
        end else begin
            r_nmi_prev <= w_nmi_s;
            r_nmi_pend <= w_nmi_fall | (r_nmi_pend & ~w_nmi_clear);
        end
    end

    // The cycle after an instruction's last cycle is its opcode fetch
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            r_first_cycle <= 1'b1;
        end else begin
            r_first_cycle <= last_cycle;
        end
    end

    // Sequencer: boundary sampling, inject cycle, service until vec_ack
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            r_state       <= c_ST_RST_PEND;
            r_src         <= c_SRC_RST;
            r_b_flag      <= 1'b0;
            r_wr_suppress <= 1'b1;
        end else begin
            case (r_state)
                c_ST_RST_PEND: begin
                    r_state <= c_ST_SERVICE;
                end
                c_ST_IDLE: begin
                    if (last_cycle && r_nmi_pend) begin
                        r_state <= c_ST_INJECT;
                        r_src   <= c_SRC_NMI;
                    end else if (last_cycle && w_irq_lvl && !p_i) begin
                        r_state <= c_ST_INJECT;
                        r_src   <= c_SRC_IRQ;
                    end else if (r_first_cycle && (data_in == BRK_OPCODE)) begin
                        r_state  <= c_ST_SERVICE;
                        r_src    <= c_SRC_BRK;
                        r_b_flag <= 1'b1;
                    end
                end
                c_ST_INJECT: begin
                    r_state <= c_ST_SERVICE;
                end
                c_ST_SERVICE: begin
                    if (vec_ack) begin
                        r_state       <= c_ST_IDLE;
                        r_wr_suppress <= 1'b0;
                        r_b_flag      <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Opcode substitution only during the inject cycle (reset uses RST_PEND)
    always_comb begin
        opcode_out = data_in;
        if ((r_state == c_ST_RST_PEND) || (r_state == c_ST_INJECT)) begin
            opcode_out = BRK_OPCODE;
        end
    end

    // Vector address decode from the latched source
    always_comb begin
        vector_addr = 16'hFFFE;
        case (r_src)
            c_SRC_RST: vector_addr = 16'hFFFC;
            c_SRC_NMI: vector_addr = 16'hFFFA;
            default:   vector_addr = 16'hFFFE;
        endcase
    end

    assign int_active  = (r_state != c_ST_IDLE);
    assign b_flag      = r_b_flag;
    assign wr_suppress = r_wr_suppress;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_interrupt_sequencer
// Description : Self-checking bench for interrupt_sequencer (default build,
//               INT_SYNC_EN undefined). Vector table rows are driven one per
//               cycle; expected outputs go into a scoreboard queue at drive
//               time and are compared on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interrupt_sequencer;

    typedef struct {
        logic        rst_n;
        logic [7:0]  d;
        logic        lc;
        logic        pi;
        logic        nmi;
        logic        irq;
        logic        va;
        logic [7:0]  op;
        logic [15:0] vec;
        logic        b;
        logic        wr;
        logic        act;
    } vec_t;

    typedef struct {
        int          tag;
        logic [7:0]  op;
        logic [15:0] vec;
        logic        b;
        logic        wr;
        logic        act;
    } exp_t;

    localparam int c_NROWS = 40;

    logic        ph1;
    logic        reset;
    logic [7:0]  data_in;
    logic        last_cycle;
    logic        p_i;
    logic        nmi_b;
    logic        irq_b;
    logic        vec_ack;
    logic [7:0]  opcode_out;
    logic [15:0] vector_addr;
    logic        b_flag;
    logic        wr_suppress;
    logic        int_active;

    vec_t tbl [c_NROWS];
    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;

    interrupt_sequencer dut (
        .ph1         (ph1),
        .reset       (reset),
        .data_in     (data_in),
        .last_cycle  (last_cycle),
        .p_i         (p_i),
        .nmi_b       (nmi_b),
        .irq_b       (irq_b),
        .vec_ack     (vec_ack),
        .opcode_out  (opcode_out),
        .vector_addr (vector_addr),
        .b_flag      (b_flag),
        .wr_suppress (wr_suppress),
        .int_active  (int_active)
    );

    initial begin
        ph1 = 1'b0;
        forever #5 ph1 = ~ph1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic rst_n, input logic [7:0] d, input logic lc, input logic pi,
                                input logic nmi, input logic irq, input logic va, input logic [7:0] op,
                                input logic [15:0] vec, input logic b, input logic wr, input logic act);
        vec_t v;
        v.rst_n = rst_n; v.d = d; v.lc = lc; v.pi = pi; v.nmi = nmi; v.irq = irq; v.va = va;
        v.op = op; v.vec = vec; v.b = b; v.wr = wr; v.act = act;
        return v;
    endfunction

    task automatic check(input string name, input int tag, input logic [15:0] act_v, input logic [15:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s (step %0d): got %h expected %h", name, tag, act_v, exp_v);
        end
    endtask

    // Pop the oldest expectation and compare every output against it
    task automatic compare_outputs();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: queue empty when output sampled, got 0 expected 1 entry");
        end else begin
            e = sb.pop_front();
            check("opcode_out",  e.tag, {8'h00, opcode_out}, {8'h00, e.op});
            check("vector_addr", e.tag, vector_addr,         e.vec);
            check("b_flag",      e.tag, {15'h0, b_flag},      {15'h0, e.b});
            check("wr_suppress", e.tag, {15'h0, wr_suppress}, {15'h0, e.wr});
            check("int_active",  e.tag, {15'h0, int_active},  {15'h0, e.act});
        end
    endtask

    task automatic drive(input vec_t v);
        reset      = v.rst_n;
        data_in    = v.d;
        last_cycle = v.lc;
        p_i        = v.pi;
        nmi_b      = v.nmi;
        irq_b      = v.irq;
        vec_ack    = v.va;
    endtask

    task automatic push_exp(input int tag, input vec_t v);
        exp_t e;
        e.tag = tag; e.op = v.op; e.vec = v.vec; e.b = v.b; e.wr = v.wr; e.act = v.act;
        sb.push_back(e);
    endtask

    initial begin
        bit   seen;
        vec_t v;

        reset = 1'b0; data_in = 8'hEA; last_cycle = 1'b0; p_i = 1'b0;
        nmi_b = 1'b1; irq_b = 1'b1; vec_ack = 1'b0;

        //            rst  d      lc  pi  nmi irq va    op     vec       b  wr act
        // reset and reset sequence
        tbl[0]  = mk(0, 8'hEA, 0, 0, 1, 1, 0, 8'h00, 16'hFFFC, 0, 1, 1);
        tbl[1]  = mk(1, 8'hEA, 0, 0, 1, 1, 0, 8'h00, 16'hFFFC, 0, 1, 1);
        tbl[2]  = mk(1, 8'hEA, 0, 0, 1, 1, 0, 8'hEA, 16'hFFFC, 0, 1, 1);
        tbl[3]  = mk(1, 8'h34, 0, 0, 1, 1, 1, 8'h34, 16'hFFFC, 0, 1, 1);
        tbl[4]  = mk(1, 8'hEA, 0, 0, 1, 1, 1, 8'hEA, 16'hFFFC, 0, 0, 0);
        // IRQ taken at boundary with I clear
        tbl[5]  = mk(1, 8'hEA, 1, 0, 1, 0, 0, 8'hEA, 16'hFFFC, 0, 0, 0);
        tbl[6]  = mk(1, 8'hA9, 0, 0, 1, 0, 0, 8'h00, 16'hFFFE, 0, 0, 1);
        tbl[7]  = mk(1, 8'h55, 0, 0, 1, 1, 0, 8'h55, 16'hFFFE, 0, 0, 1);
        tbl[8]  = mk(1, 8'h56, 0, 1, 1, 1, 1, 8'h56, 16'hFFFE, 0, 0, 1);
        // IRQ masked by I, then IRQ withdrawn before the boundary
        tbl[9]  = mk(1, 8'hEA, 1, 1, 1, 0, 0, 8'hEA, 16'hFFFE, 0, 0, 0);
        tbl[10] = mk(1, 8'hA9, 0, 1, 1, 0, 0, 8'hA9, 16'hFFFE, 0, 0, 0);
        tbl[11] = mk(1, 8'hEA, 1, 0, 1, 1, 0, 8'hEA, 16'hFFFE, 0, 0, 0);
        tbl[12] = mk(1, 8'hA9, 0, 0, 1, 1, 0, 8'hA9, 16'hFFFE, 0, 0, 0);
        // NMI edge with IRQ also asserted: NMI has priority
        tbl[13] = mk(1, 8'hEA, 0, 0, 0, 0, 0, 8'hEA, 16'hFFFE, 0, 0, 0);
        tbl[14] = mk(1, 8'hEA, 1, 0, 0, 0, 0, 8'hEA, 16'hFFFE, 0, 0, 0);
        tbl[15] = mk(1, 8'hA9, 0, 0, 0, 0, 0, 8'h00, 16'hFFFA, 0, 0, 1);
        tbl[16] = mk(1, 8'h11, 0, 0, 0, 1, 1, 8'h11, 16'hFFFA, 0, 0, 1);
        // NMI held low: no second entry
        tbl[17] = mk(1, 8'hEA, 1, 0, 0, 1, 0, 8'hEA, 16'hFFFA, 0, 0, 0);
        tbl[18] = mk(1, 8'hA9, 0, 0, 0, 1, 0, 8'hA9, 16'hFFFA, 0, 0, 0);
        // second NMI edge coincides with vec_ack of the first
        tbl[19] = mk(1, 8'hEA, 0, 0, 1, 1, 0, 8'hEA, 16'hFFFA, 0, 0, 0);
        tbl[20] = mk(1, 8'hEA, 0, 0, 0, 1, 0, 8'hEA, 16'hFFFA, 0, 0, 0);
        tbl[21] = mk(1, 8'hEA, 1, 0, 1, 1, 0, 8'hEA, 16'hFFFA, 0, 0, 0);
        tbl[22] = mk(1, 8'hA9, 0, 0, 1, 1, 0, 8'h00, 16'hFFFA, 0, 0, 1);
        tbl[23] = mk(1, 8'h22, 0, 0, 0, 1, 1, 8'h22, 16'hFFFA, 0, 0, 1);
        tbl[24] = mk(1, 8'hEA, 1, 0, 0, 1, 0, 8'hEA, 16'hFFFA, 0, 0, 0);
        tbl[25] = mk(1, 8'hA9, 0, 0, 0, 1, 0, 8'h00, 16'hFFFA, 0, 0, 1);
        tbl[26] = mk(1, 8'h33, 0, 0, 0, 1, 1, 8'h33, 16'hFFFA, 0, 0, 1);
        // software BRK on an opcode fetch
        tbl[27] = mk(1, 8'hEA, 1, 0, 0, 1, 0, 8'hEA, 16'hFFFA, 0, 0, 0);
        tbl[28] = mk(1, 8'h00, 0, 0, 0, 1, 0, 8'h00, 16'hFFFA, 0, 0, 0);
        tbl[29] = mk(1, 8'h44, 0, 0, 0, 1, 0, 8'h44, 16'hFFFE, 1, 0, 1);
        tbl[30] = mk(1, 8'h45, 0, 0, 0, 1, 1, 8'h45, 16'hFFFE, 1, 0, 1);
        tbl[31] = mk(1, 8'hEA, 0, 0, 1, 1, 0, 8'hEA, 16'hFFFE, 0, 0, 0);
        // reset during IRQ service with an NMI pending
        tbl[32] = mk(1, 8'hEA, 1, 0, 1, 0, 0, 8'hEA, 16'hFFFE, 0, 0, 0);
        tbl[33] = mk(1, 8'hA9, 0, 0, 1, 0, 0, 8'h00, 16'hFFFE, 0, 0, 1);
        tbl[34] = mk(1, 8'h12, 0, 0, 0, 0, 0, 8'h12, 16'hFFFE, 0, 0, 1);
        tbl[35] = mk(0, 8'h13, 0, 0, 0, 1, 0, 8'h00, 16'hFFFC, 0, 1, 1);
        tbl[36] = mk(1, 8'hEA, 0, 0, 1, 1, 0, 8'h00, 16'hFFFC, 0, 1, 1);
        tbl[37] = mk(1, 8'hEA, 0, 0, 1, 1, 1, 8'hEA, 16'hFFFC, 0, 1, 1);
        tbl[38] = mk(1, 8'hEA, 1, 0, 1, 1, 0, 8'hEA, 16'hFFFC, 0, 0, 0);
        tbl[39] = mk(1, 8'hA9, 0, 0, 1, 1, 0, 8'hA9, 16'hFFFC, 0, 0, 0);

        for (int i = 0; i < c_NROWS; i++) begin
            @(posedge ph1);
            #1;
            drive(tbl[i]);
            push_exp(i, tbl[i]);
            @(negedge ph1);
            compare_outputs();
        end

        // Asynchronous reset takes effect without waiting for a clock edge
        @(posedge ph1);
        #1;
        v = mk(0, 8'h77, 0, 0, 1, 1, 0, 8'h00, 16'hFFFC, 0, 1, 1);
        drive(v);
        push_exp(100, v);
        #2;
        compare_outputs();

        // Release with vec_ack held: reset sequence must end within a bound
        @(posedge ph1);
        #1;
        v = mk(1, 8'hEA, 0, 0, 1, 1, 1, 8'hEA, 16'hFFFC, 0, 0, 0);
        drive(v);
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            @(negedge ph1);
            if (!int_active) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL reset_sequence_end: int_active stayed 1, expected 0 within 8 cycles");
        end
        push_exp(101, v);
        compare_outputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
